usr_burst_shifter: RTL and testbench
====================================

# usr_burst_shifter

Parametrised universal shift register with eight operating modes: hold, logical shifts with serial inputs, parallel load, rotates, arithmetic right shift and clear. It adds a burst engine that performs a programmed number of shift or rotate steps autonomously, with busy/done status. It is the next-generation replacement for the 4-bit universal shift register and sits in datapaths needing serialisers, barrel-style multi-step shifts or bit-stream generators.

## Interface
- WIDTH, 8: register width in bits, ≥2.
- SW, $clog2(WIDTH)+1: shift-count width; must represent WIDTH.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  single-step enable; applies mode for one cycle when idle.
- mode  in  3  operation select (see Operation).
- din  in  WIDTH  parallel load data.
- sin_msb  in  1  serial bit entering the MSB on logical shift right.
- sin_lsb  in  1  serial bit entering the LSB on shift left.
- start  in  1  burst request; samples mode and shamt.
- shamt  in  SW  burst step count.
- dout  out  WIDTH  register contents.
- sout_lsb  out  1  dout[0], combinational from the register.
- sout_msb  out  1  dout[WIDTH-1], combinational from the register.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.

## Operation
- Modes:
  - 000 hold.
  - 001 SHR: {sin_msb, dout[W-1:1]}.
  - 010 SHL: {dout[W-2:0], sin_lsb}.
  - 011 load din.
  - 100 ROR: {dout[0], dout[W-1:1]}.
  - 101 ROL: {dout[W-2:0], dout[W-1]}.
  - 110 ASR: {dout[W-1], dout[W-1:1]}.
  - 111 clear to 0.
- Shift modes are 001, 010, 100, 101 and 110.
- Two states, IDLE and BURST. Internal registers are the latched burst mode (3 bits) and the remaining count (SW bits).
- IDLE, start=1:
  - If shamt≠0 and mode is a shift mode: latch mode, set count=shamt, go to BURST, busy=1. dout does not change on this edge.
  - Otherwise: dout is unchanged, done=1 for one cycle, and the state stays IDLE.
  - start has priority over en on the same edge.
- IDLE, start=0, en=1: apply mode once to dout.
- IDLE, start=0, en=0: hold.
- BURST, each edge:
  - Apply the latched mode once and decrement count.
  - When count goes 1→0: return to IDLE, busy=0, done=1 for one cycle.
  - en, mode and start are ignored while busy. A start during a burst is dropped, not queued.
  - sin_msb and sin_lsb are sampled live on every step.
- shamt > WIDTH is legal and is executed literally. A rotate wraps around; a logical shift fully flushes to serial-input bits.
- Reset (rst_n=0), asynchronous and applied at any time including mid-burst:
  - dout=0, busy=0, done=0, state=IDLE, count=0.
  - The aborted burst produces no done.

## Timing
- Single step: dout updates on the edge where en=1 is sampled, i.e. 1-cycle latency.
- Burst with N≥1, start sampled at edge E0:
  - Shifts occur at edges E1..EN.
  - busy is high after E0 through EN and falls after EN.
  - done is high for exactly the cycle following EN.
- Degenerate start (N=0, or a non-shift mode): done is high for the cycle following E0; busy never rises.
- A new start is accepted in the cycle where done is high, because the block is already in IDLE.
- Reset release: the first functional edge is the first rising clk edge with rst_n=1.
- sout_lsb and sout_msb follow dout with no additional register stage.

## Test plan
- Reset: drive random inputs, assert rst_n=0 mid-cycle → dout=0x00, busy=0 and done=0 immediately, without waiting for a clock edge.
- Single-step modes, WIDTH=8:
  - Load 0xA5 → 0xA5.
  - ROR 0xA5 → 0xD2; ROL 0xA5 → 0x4B.
  - SHR 0x01 with sin_msb=1 → 0x80.
  - SHL 0x81 with sin_lsb=0 → 0x02.
  - ASR 0x80 → 0xC0; ASR 0x40 → 0x20.
  - Clear → 0x00.
  - en=0 → dout holds.
- Burst from dout=0x01, start with mode=101, shamt=3:
  - Drive mode=111, en=1 and start=1 during busy → all ignored.
  - busy is high for 3 cycles; dout steps 0x02, 0x04, 0x08.
  - done pulses once, in the cycle after the last shift.
- Degenerate bursts: start with shamt=0, and start with mode=011 → dout unchanged, busy stays 0, done is a 1-cycle pulse after the start edge.
- Long SHR burst: dout=0xFF, sin_msb=0, shamt=9 → 0x00 after 9 shifts; busy high for 9 cycles.
- Back-to-back and abort:
  - Issue a second start during the done cycle → accepted; busy rises on that edge.
  - Assert rst_n=0 after 2 of 5 steps → dout=0, busy=0, no done; the block is idle after release.

Source files
------------

// File: rtl/usr_burst_shifter_if.sv
// Control/data bundle for the burst shifter: request side drives, shifter returns state.
// No handshake; requests are sampled every edge and status is registered.
interface usr_burst_shifter_if #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH) + 1
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] din;
  logic             sin_msb;
  logic             sin_lsb;
  logic             start;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] dout;
  logic             sout_lsb;
  logic             sout_msb;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, din, sin_msb, sin_lsb, start, shamt,
    input  dout, sout_lsb, sout_msb, busy, done
  );

  modport slave (
    input  en, mode, din, sin_msb, sin_lsb, start, shamt,
    output dout, sout_lsb, sout_msb, busy, done
  );
endinterface

// File: rtl/usr_burst_shifter.sv
// Universal shift register with an autonomous N-step burst engine; 1-cycle step latency.
// No backpressure: requests (en/start) arriving while busy are dropped, not queued.
module usr_burst_shifter #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  usr_burst_shifter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [2:0]       bmode_q, bmode_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             burst_ok;
  logic             last_step;

  function automatic logic is_shift(input logic [2:0] m);
    return (m == M_SHR) || (m == M_SHL) || (m == M_ROR) || (m == M_ROL) || (m == M_ASR);
  endfunction

  function automatic logic [WIDTH-1:0] apply_mode(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] ld,
    input logic             smsb,
    input logic             slsb
  );
    logic [WIDTH-1:0] r;
    case (m)
      M_HOLD:  r = v;
      M_SHR:   r = {smsb, v[WIDTH-1:1]};
      M_SHL:   r = {v[WIDTH-2:0], slsb};
      M_LOAD:  r = ld;
      M_ROR:   r = {v[0], v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      M_CLR:   r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  assign burst_ok  = (bus.shamt != '0) && is_shift(bus.mode);
  assign last_step = (cnt_q == SW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && burst_ok) state_d = BURST;
      BURST:   if (last_step)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; start outranks en, and both are ignored mid-burst
  always_comb begin
    dout_d  = dout_q;
    bmode_d = bmode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (burst_ok) begin
            bmode_d = bus.mode;
            cnt_d   = bus.shamt;
          end else begin
            done_d = 1'b1;
          end
        end else if (bus.en) begin
          dout_d = apply_mode(bus.mode, dout_q, bus.din, bus.sin_msb, bus.sin_lsb);
        end
      end
      BURST: begin
        dout_d = apply_mode(bmode_q, dout_q, bus.din, bus.sin_msb, bus.sin_lsb);
        cnt_d  = cnt_q - SW'(1);
        done_d = last_step;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      bmode_q <= M_HOLD;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      bmode_q <= bmode_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs
  always_comb begin
    bus.dout     = dout_q;
    bus.sout_lsb = dout_q[0];
    bus.sout_msb = dout_q[WIDTH-1];
    bus.busy     = (state_q == BURST);
    bus.done     = done_q;
  end

endmodule

// File: tb/tb_usr_burst_shifter.sv
// Directed bench for usr_burst_shifter (WIDTH=8): single-step modes, bursts, degenerate starts, abort.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_usr_burst_shifter;

  localparam int WIDTH = 8;
  localparam int SW    = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  usr_burst_shifter_if #(.WIDTH(WIDTH), .SW(SW)) bus ();

  usr_burst_shifter #(.WIDTH(WIDTH), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en      = 1'b0;
    bus.mode    = 3'b000;
    bus.din     = '0;
    bus.sin_msb = 1'b0;
    bus.sin_lsb = 1'b0;
    bus.start   = 1'b0;
    bus.shamt   = '0;
  endtask

  task automatic load(input logic [7:0] v);
    bus.en   = 1'b1;
    bus.mode = 3'b011;
    bus.din  = v;
    tick();
    idle_inputs();
  endtask

  task automatic single(input logic [2:0] m, input logic smsb, input logic slsb);
    bus.en      = 1'b1;
    bus.mode    = m;
    bus.sin_msb = smsb;
    bus.sin_lsb = slsb;
    tick();
    idle_inputs();
  endtask

  task automatic start_burst(input logic [2:0] m, input logic [3:0] n);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.shamt = n;
    tick();
    idle_inputs();
  endtask

  initial begin
    logic [7:0] exp_v;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle_inputs();
    #2;
    chk_eq("por_dout", bus.dout, 8'h00);
    chk_eq("por_busy", bus.busy, 1'b0);
    chk_eq("por_done", bus.done, 1'b0);
    tick();
    rst_n = 1'b1;

    // Single-step modes
    load(8'hA5);             chk_eq("load_a5", bus.dout, 8'hA5);
    single(3'b100, 0, 0);    chk_eq("ror_a5", bus.dout, 8'hD2);
    load(8'hA5);
    single(3'b101, 0, 0);    chk_eq("rol_a5", bus.dout, 8'h4B);
    load(8'h01);
    single(3'b001, 1, 0);    chk_eq("shr_sin1", bus.dout, 8'h80);
    load(8'h81);
    chk_eq("sout_lsb_81", bus.sout_lsb, 1'b1);
    chk_eq("sout_msb_81", bus.sout_msb, 1'b1);
    single(3'b010, 0, 0);    chk_eq("shl_81", bus.dout, 8'h02);
    chk_eq("sout_lsb_02", bus.sout_lsb, 1'b0);
    load(8'h80);
    single(3'b110, 0, 0);    chk_eq("asr_80", bus.dout, 8'hC0);
    load(8'h40);
    single(3'b110, 0, 0);    chk_eq("asr_40", bus.dout, 8'h20);
    load(8'hA5);
    single(3'b111, 0, 0);    chk_eq("clear", bus.dout, 8'h00);
    load(8'h5A);
    bus.mode = 3'b011; bus.din = 8'hFF;
    tick(); tick();          chk_eq("en0_hold", bus.dout, 8'h5A);
    idle_inputs();
    single(3'b000, 1, 1);    chk_eq("mode_hold", bus.dout, 8'h5A);

    // ROL burst of 3 with distractions while busy
    load(8'h01);
    start_burst(3'b101, 4'd3);
    chk_eq("b_e0_dout", bus.dout, 8'h01);
    chk_eq("b_e0_busy", bus.busy, 1'b1);
    chk_eq("b_e0_done", bus.done, 1'b0);
    bus.mode = 3'b111; bus.en = 1'b1; bus.start = 1'b1; bus.shamt = 4'd2;
    tick();
    chk_eq("b_e1_dout", bus.dout, 8'h02);
    chk_eq("b_e1_busy", bus.busy, 1'b1);
    chk_eq("b_e1_done", bus.done, 1'b0);
    tick();
    chk_eq("b_e2_dout", bus.dout, 8'h04);
    chk_eq("b_e2_busy", bus.busy, 1'b1);
    idle_inputs();
    tick();
    chk_eq("b_e3_dout", bus.dout, 8'h08);
    chk_eq("b_e3_busy", bus.busy, 1'b0);
    chk_eq("b_e3_done", bus.done, 1'b1);
    tick();
    chk_eq("b_e4_done", bus.done, 1'b0);
    chk_eq("b_e4_dout", bus.dout, 8'h08);

    // Degenerate starts
    start_burst(3'b101, 4'd0);
    chk_eq("dz_dout", bus.dout, 8'h08);
    chk_eq("dz_busy", bus.busy, 1'b0);
    chk_eq("dz_done", bus.done, 1'b1);
    tick();
    chk_eq("dz_done_off", bus.done, 1'b0);
    bus.din = 8'hFF;
    start_burst(3'b011, 4'd4);
    chk_eq("dl_dout", bus.dout, 8'h08);
    chk_eq("dl_busy", bus.busy, 1'b0);
    chk_eq("dl_done", bus.done, 1'b1);
    tick();
    chk_eq("dl_done_off", bus.done, 1'b0);

    // Long SHR burst flushes past WIDTH
    load(8'hFF);
    start_burst(3'b001, 4'd9);
    chk_eq("l_e0_busy", bus.busy, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_v = (i >= 8) ? 8'h00 : (8'hFF >> i);
      chk_eq($sformatf("l_e%0d_dout", i), bus.dout, exp_v);
      chk_eq($sformatf("l_e%0d_busy", i), bus.busy, (i < 9) ? 1'b1 : 1'b0);
      chk_eq($sformatf("l_e%0d_done", i), bus.done, (i == 9) ? 1'b1 : 1'b0);
    end
    tick();
    chk_eq("l_done_off", bus.done, 1'b0);

    // Back-to-back: second start during the done cycle
    load(8'h03);
    start_burst(3'b101, 4'd2);
    tick();                  chk_eq("bb_e1", bus.dout, 8'h06);
    tick();                  chk_eq("bb_e2", bus.dout, 8'h0C);
    chk_eq("bb_done", bus.done, 1'b1);
    start_burst(3'b100, 4'd1);
    chk_eq("bb2_busy", bus.busy, 1'b1);
    chk_eq("bb2_dout", bus.dout, 8'h0C);
    chk_eq("bb2_done", bus.done, 1'b0);
    tick();
    chk_eq("bb2_dout_end", bus.dout, 8'h06);
    chk_eq("bb2_busy_end", bus.busy, 1'b0);
    chk_eq("bb2_done_end", bus.done, 1'b1);

    // Abort after 2 of 5 steps
    load(8'h01);
    start_burst(3'b101, 4'd5);
    tick(); tick();
    chk_eq("ab_pre", bus.dout, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("ab_dout", bus.dout, 8'h00);
    chk_eq("ab_busy", bus.busy, 1'b0);
    chk_eq("ab_done", bus.done, 1'b0);
    tick();
    chk_eq("ab_in_rst_done", bus.done, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_eq("ab_rel_busy", bus.busy, 1'b0);
    chk_eq("ab_rel_done", bus.done, 1'b0);
    chk_eq("ab_rel_dout", bus.dout, 8'h00);
    load(8'h3C);
    chk_eq("ab_idle_load", bus.dout, 8'h3C);

    // Mid-cycle reset with random inputs applied
    load(8'hA5);
    bus.en      = 1'($urandom);
    bus.mode    = 3'($urandom);
    bus.din     = 8'($urandom);
    bus.sin_msb = 1'($urandom);
    bus.sin_lsb = 1'($urandom);
    #3 rst_n = 1'b0;
    #1;
    chk_eq("rr_dout", bus.dout, 8'h00);
    chk_eq("rr_busy", bus.busy, 1'b0);
    chk_eq("rr_done", bus.done, 1'b0);
    tick();
    chk_eq("rr_held", bus.dout, 8'h00);
    idle_inputs();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
